pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_reg_chain.sv | 85 ++++++++
 tb/tb_pipe_reg_chain.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Bubble-collapsing register chain of DEPTH stages with valid/ready handshake, flush and occupancy.
// Optional occupancy counter compiled only with macro PIPE_REG_CHAIN_OCC_COUNT_EN (else tied to 0).
module pipe_reg_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             in_xfer;

  // Stage i can move iff some stage at or downstream of it is empty, or the sink drains.
  // Computed per stage without a chained vector to keep the comb network acyclic.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic full_above;
      full_above = 1'b1;
      for (int j = i; j < DEPTH; j++) full_above = full_above & valid[j];
      rdy[i] = !full_above | out_ready;
    end
  end

  assign in_ready  = rdy[0] & !flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = valid[DEPTH-1] & !flush;
  assign out_data  = data[DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      if (rdy[0]) begin
        valid[0] <= in_xfer;
        if (in_xfer) data[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          valid[i] <= valid[i-1];
          if (valid[i-1]) data[i] <= data[i-1];
        end
      end
    end
  end

`ifdef PIPE_REG_CHAIN_OCC_COUNT_EN
  logic          out_xfer;
  logic [OW-1:0] occ_q;

  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ_q <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occupancy = occ_q;
`else
  assign occupancy = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (WIDTH=32, DEPTH=3): directed vector table, then random traffic vs a queue model.
module tb_pipe_reg_chain;
  localparam int W = 32;
  localparam int D = 3;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [1:0]    occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [31:0] e_od;
    int          e_occ;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic [31:0] d, logic ordy,
                              logic e_ir, logic e_ov, logic [31:0] e_od, int e_occ);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    return v;
  endfunction

  function automatic int occ_exp(int n);
`ifdef PIPE_REG_CHAIN_OCC_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Reference model: words in order, each with its stage index.
  logic [31:0] qd[$];
  int          qs[$];
  logic [31:0] last_out;

  initial begin
    // rst fl iv data ordy | in_ready out_valid out_data occ
    vt.push_back(mk(0,0,1,32'h11,1, 1,0,32'h00,0));
    vt.push_back(mk(0,0,1,32'h22,1, 1,0,32'h00,1));
    vt.push_back(mk(0,0,1,32'h33,1, 1,0,32'h00,2));
    vt.push_back(mk(0,0,0,32'h00,1, 1,1,32'h11,3));
    vt.push_back(mk(0,0,0,32'h00,1, 1,1,32'h22,2));
    vt.push_back(mk(0,0,0,32'h00,1, 1,1,32'h33,1));
    vt.push_back(mk(0,0,0,32'h00,1, 1,0,32'h33,0));
    // backpressure: fourth push refused
    vt.push_back(mk(0,0,1,32'hA0,0, 1,0,32'h33,0));
    vt.push_back(mk(0,0,1,32'hA1,0, 1,0,32'h33,1));
    vt.push_back(mk(0,0,1,32'hA2,0, 1,0,32'h33,2));
    vt.push_back(mk(0,0,1,32'hA3,0, 0,1,32'hA0,3));
    // full chain, simultaneous in and out
    vt.push_back(mk(0,0,1,32'hB0,1, 1,1,32'hA0,3));
    vt.push_back(mk(0,0,0,32'h00,1, 1,1,32'hA1,3));
    vt.push_back(mk(0,0,0,32'h00,1, 1,1,32'hA2,2));
    vt.push_back(mk(0,0,0,32'h00,1, 1,1,32'hB0,1));
    vt.push_back(mk(0,0,0,32'h00,1, 1,0,32'hB0,0));
    // flush with two words in flight
    vt.push_back(mk(0,0,1,32'hC0,0, 1,0,32'hB0,0));
    vt.push_back(mk(0,0,1,32'hC1,0, 1,0,32'hB0,1));
    vt.push_back(mk(0,1,1,32'hC2,1, 0,0,32'hB0,2));
    vt.push_back(mk(0,0,0,32'h00,1, 1,0,32'hB0,0));
    // reset of a full chain
    vt.push_back(mk(0,0,1,32'hD0,0, 1,0,32'hB0,0));
    vt.push_back(mk(0,0,1,32'hD1,0, 1,0,32'hB0,1));
    vt.push_back(mk(0,0,1,32'hD2,0, 1,0,32'hB0,2));
    vt.push_back(mk(0,0,0,32'h00,0, 0,1,32'hD0,3));
    vt.push_back(mk(1,0,1,32'hEE,0, 0,1,32'hD0,3));
    vt.push_back(mk(0,0,0,32'h00,0, 1,0,32'h00,0));

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_in_ready", -1, 32'(in_ready), 32'd1);
    check("reset_out_valid", -1, 32'(out_valid), 32'd0);
    check("reset_out_data", -1, out_data, 32'd0);
    check("reset_occ", -1, 32'(occupancy), 32'd0);

    foreach (vt[i]) begin
      @(negedge clk);
      reset = vt[i].rst; flush = vt[i].fl; in_valid = vt[i].iv;
      in_data = vt[i].d; out_ready = vt[i].ordy;
      #1;
      check("vec_in_ready", i, 32'(in_ready), 32'(vt[i].e_ir));
      check("vec_out_valid", i, 32'(out_valid), 32'(vt[i].e_ov));
      check("vec_out_data", i, out_data, vt[i].e_od);
      check("vec_occ", i, 32'(occupancy), 32'(occ_exp(vt[i].e_occ)));
    end

    // Random traffic against the queue model; the directed run ends empty with zeroed data.
    last_out = '0;
    for (int c = 0; c < 3000; c++) begin
      logic exp_ov, exp_ir;
      int   lim, ns;
      @(negedge clk);
      reset     = ($urandom_range(0, 149) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      #1;
      exp_ov = !flush && qd.size() > 0 && qs[0] == D-1;
      exp_ir = !flush && (qd.size() < D || out_ready);
      check("rnd_in_ready", c, 32'(in_ready), 32'(exp_ir));
      check("rnd_out_valid", c, 32'(out_valid), 32'(exp_ov));
      check("rnd_out_data", c, out_data, last_out);
      check("rnd_occ", c, 32'(occupancy), 32'(occ_exp(qd.size())));
      @(posedge clk);
      if (reset) begin
        qd.delete(); qs.delete(); last_out = '0;
      end else if (flush) begin
        qd.delete(); qs.delete();
      end else begin
        if (exp_ov && out_ready) begin
          void'(qd.pop_front()); void'(qs.pop_front());
        end
        if (in_valid && exp_ir) begin
          qd.push_back(in_data); qs.push_back(-1);
        end
        // Each word advances one stage unless blocked by the word ahead of it.
        lim = D - 1;
        for (int k = 0; k < qs.size(); k++) begin
          ns = (qs[k] + 1 < lim) ? qs[k] + 1 : lim;
          qs[k] = ns;
          lim = ns - 1;
        end
        if (qd.size() > 0 && qs[0] == D-1) last_out = qd[0];
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
